// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state encodings for the multiply/divide unit and its issuer (stage_ex).
package muldiv_unit_pkg;

    localparam int MULDIV_OPT_WIDTH = 3;

    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MULT  = 3'd0;
    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MULTU = 3'd1;
    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_DIV   = 3'd2;
    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_DIVU  = 3'd3;
    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MTHI  = 3'd4;
    localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MTLO  = 3'd5;
    // codes 6 and 7 are undefined and raise illegal_opt

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    localparam int STEPS = 32;

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring shift-subtract divide step.
module muldiv_iter_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               mode_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;

    // Multiply: acc = {partial, multiplier}, LSB of multiplier gates the add, then shift right.
    // Divide:   acc = {remainder, dividend}, shift left and try to subtract the divisor.
    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, (acc_in[0] ? opnd : {WIDTH{1'b0}})};
        diff    = {1'b0, acc_in[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
        if (!mode_div)
            acc_out = {sum, acc_in[WIDTH-1:1]};
        else if (!diff[WIDTH+1])
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO; 32 step cycles plus a sign-fixup cycle.
// Optional MULDIV_FAST_MULT_EN: MULT/MULTU complete in a single cycle via a 64-bit multiply.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MULDIV_OPT_WIDTH-1:0] opt,
    input  logic [WIDTH-1:0]            opr1,
    input  logic [WIDTH-1:0]            opr2,
    input  logic                        cancel,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            hi,
    output logic [WIDTH-1:0]            lo,
    output logic                        illegal_opt
);

    muldiv_state_e        state, state_nxt;
    logic [4:0]           cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div, neg_lo, neg_hi, div_zero;

    logic                 accept, op_arith, op_div, op_signed, op_iter;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   res_mul;
    logic [WIDTH-1:0]     res_quo, res_rem;

    assign busy      = (state != ST_IDLE);
    assign accept    = start && (state == ST_IDLE) && !cancel;
    assign op_arith  = (opt == MULDIV_OPT_MULT) || (opt == MULDIV_OPT_MULTU) ||
                       (opt == MULDIV_OPT_DIV)  || (opt == MULDIV_OPT_DIVU);
    assign op_div    = (opt == MULDIV_OPT_DIV)  || (opt == MULDIV_OPT_DIVU);
    assign op_signed = (opt == MULDIV_OPT_MULT) || (opt == MULDIV_OPT_DIV);
    assign mag1      = (op_signed && opr1[WIDTH-1]) ? -opr1 : opr1;
    assign mag2      = (op_signed && opr2[WIDTH-1]) ? -opr2 : opr2;

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*WIDTH-1:0] fast_s;
    logic        [2*WIDTH-1:0] fast_u, fast_prod;
    assign fast_s    = $signed({{WIDTH{opr1[WIDTH-1]}}, opr1}) * $signed({{WIDTH{opr2[WIDTH-1]}}, opr2});
    assign fast_u    = {{WIDTH{1'b0}}, opr1} * {{WIDTH{1'b0}}, opr2};
    assign fast_prod = op_signed ? fast_s : fast_u;
    assign op_iter   = op_div;
`else
    assign op_iter   = op_arith;
`endif

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (is_div),
        .acc_in   (acc),
        .opnd     (opnd),
        .acc_out  (acc_nxt)
    );

    // Divide by zero: the iteration leaves |opr1| in the remainder, so the
    // remainder fixup restores opr1 and only the quotient needs overriding.
    assign res_mul = neg_lo ? -acc : acc;
    assign res_quo = div_zero ? {WIDTH{1'b1}} : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign res_rem = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept && op_iter) state_nxt = ST_RUN;
            ST_RUN:  if (cancel) state_nxt = ST_IDLE;
                     else if (cnt == 5'(STEPS - 1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            illegal_opt <= 1'b0;
        end else begin
            done        <= 1'b0;
            illegal_opt <= 1'b0;
            unique case (state)
                ST_IDLE: if (accept) begin
                    if (opt == MULDIV_OPT_MTHI) begin
                        hi   <= opr1;
                        done <= 1'b1;
                    end else if (opt == MULDIV_OPT_MTLO) begin
                        lo   <= opr1;
                        done <= 1'b1;
                    end else if (!op_arith) begin
                        illegal_opt <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                    end else if (!op_div) begin
                        {hi, lo} <= fast_prod;
                        done     <= 1'b1;
`endif
                    end else begin
                        acc      <= op_div ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
                        opnd     <= op_div ? mag2 : mag1;
                        is_div   <= op_div;
                        neg_lo   <= op_signed && (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
                        neg_hi   <= op_signed && opr1[WIDTH-1];
                        div_zero <= (opr2 == '0);
                        cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        cnt <= '0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_FIX: begin
                    cnt <= '0;
                    if (!cancel) begin
                        if (is_div) {hi, lo} <= {res_rem, res_quo};
                        else        {hi, lo} <= res_mul;
                        done <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, monitor pops on done.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [2:0]  opt;
    logic [31:0] opr1, opr2;
    logic        busy, done, illegal_opt;
    logic [31:0] hi, lo;

    typedef struct {
        logic [63:0] res;
        int          id;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          op_id = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opt(opt), .opr1(opr1), .opr2(opr2),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo), .illegal_opt(illegal_opt)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on 64-bit integers, result as {hi, lo}
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, b,
                                              input logic [31:0] ch, cl);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = {ch, cl};
        case (o)
            MULDIV_OPT_MULT:  r = 64'(sa * sb);
            MULDIV_OPT_MULTU: r = {32'b0, a} * {32'b0, b};
            MULDIV_OPT_DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            MULDIV_OPT_DIV:   r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            MULDIV_OPT_MTHI:  r = {a, cl};
            MULDIV_OPT_MTLO:  r = {ch, a};
            default:          r = {ch, cl};
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, b, input bit push);
        exp_t e;
        wait_idle();
        opt = o; opr1 = a; opr2 = b; start = 1'b1;
        if (push) begin
            e.res = ref_model(o, a, b, m_hi, m_lo);
            e.id  = op_id++;
            sbq.push_back(e);
            {m_hi, m_lo} = e.res;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_chk(input string nm, input logic [2:0] o, input logic [31:0] a, b,
                             input logic [63:0] exp);
        issue(o, a, b, 1'b1);
        wait_idle();
        @(negedge clk);
        chk(nm, {hi, lo}, exp);
    endtask

    // Monitor: every done pulse consumes exactly one expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("result_%0d", e.id), {hi, lo}, e.res);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, exp_busy;
        logic [2:0]  o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; opt = '0; opr1 = '0; opr2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {61'b0, busy, done, illegal_opt}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MULT -3 * 7 with latency check
`ifdef MULDIV_FAST_MULT_EN
        exp_busy = 0;
`else
        exp_busy = 33;
`endif
        issue(MULDIV_OPT_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mult_busy_cycles", 64'(n), 64'(exp_busy));
        chk("mult_done_timing", 64'(done), 64'd1);
        chk("mult_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);

        issue_chk("multu_max", MULDIV_OPT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        issue_chk("divu_100_7", MULDIV_OPT_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        issue_chk("div_m7_2", MULDIV_OPT_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        issue_chk("div_5_0", MULDIV_OPT_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
        issue_chk("div_neg_by_0", MULDIV_OPT_DIV, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF);
        issue_chk("div_ovf", MULDIV_OPT_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        // MT preload, busy must stay low
        issue(MULDIV_OPT_MTHI, 32'h11111111, 32'd0, 1'b1);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(MULDIV_OPT_MTLO, 32'h22222222, 32'd0, 1'b1);
        chk("mtlo_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("mt_preload", {hi, lo}, 64'h11111111_22222222);

        // Cancel at step 10
        issue(MULDIV_OPT_DIVU, 32'd12345, 32'd17, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hilo", {hi, lo}, 64'h11111111_22222222);

        // Reset at step 20
        issue(MULDIV_OPT_DIVU, 32'd12345, 32'd17, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_flags", {62'b0, busy, done}, 64'd0);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);

        // MTHI pulse while busy is ignored
        issue(MULDIV_OPT_DIVU, 32'd1000, 32'd3, 1'b1);
        opt = MULDIV_OPT_MTHI; opr1 = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("mthi_while_busy", {hi, lo}, {32'd1, 32'd333});

        // Undefined opcode
        opt = 3'd7; opr1 = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_pulse", 64'(illegal_opt), 64'd1);
        @(negedge clk);
        chk("illegal_clear", 64'(illegal_opt), 64'd0);
        chk("illegal_hilo", {hi, lo}, {32'd1, 32'd333});

        // cancel with start in IDLE drops the request
        opt = MULDIV_OPT_MTLO; opr1 = 32'h5A5A5A5A; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_hilo", {hi, lo}, {32'd1, 32'd333});

        // Randomized traffic, back to back
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            issue(o, a, b, 1'b1);
        end
        wait_idle();

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
